// File: rtl/sha3_pkg.sv
// Shared types and widths for the SHA3-512 message feeder: FSM state encoding
// and the byte/word/digest dimensions of the keccak core interface.
package sha3_pkg;

  localparam int BYTE_W   = 8;
  localparam int WORD_W   = 64;
  localparam int DIGEST_W = 512;
  localparam int LANES    = WORD_W / BYTE_W;
  localparam int CNT_W    = 4;  // holds 0..LANES inclusive

  typedef enum logic [2:0] {
    ST_KRST,
    ST_FILL,
    ST_SEND,
    ST_SENDZ,
    ST_WAIT,
    ST_DONE
  } state_e;

endpackage

// File: rtl/sha3_byte_packer.sv
// Packs bytes MSB-first into a 64-bit word: lane 0 is [63:56]. The word and
// lane counter clear together when the word is consumed by the core.
module sha3_byte_packer
  import sha3_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              wr_en_i,
  input  logic [BYTE_W-1:0] byte_i,
  input  logic              clr_i,
  output logic [WORD_W-1:0] word_o,
  output logic [CNT_W-1:0]  cnt_o
);

  logic [WORD_W-1:0] word_q, word_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // NOTE: defaults first so every path assigns word_d/cnt_d and no latch is inferred.
  always_comb begin
    word_d = word_q;
    cnt_d  = cnt_q;
    if (clr_i) begin
      word_d = '0;
      cnt_d  = '0;
    end else if (wr_en_i && (cnt_q < CNT_W'(LANES))) begin
      for (int lane = 0; lane < LANES; lane++) begin
        if (cnt_q == CNT_W'(lane)) word_d[WORD_W-1-lane*BYTE_W -: BYTE_W] = byte_i;
      end
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      word_q <= '0;
      cnt_q  <= '0;
    end else begin
      word_q <= word_d;
      cnt_q  <= cnt_d;
    end
  end

  assign word_o = word_q;
  assign cnt_o  = cnt_q;

endmodule

// File: rtl/sha3_msg_feeder.sv
// Message-side front end for the SHA3-512 keccak core: byte stream in, 64-bit
// words out with back-pressure, digest capture and per-message core reset.
module sha3_msg_feeder
  import sha3_pkg::*;
#(
  parameter int KRST_CYCLES = 1
) (
  input  logic                iClk,
  input  logic                iRst_n,
  input  logic [BYTE_W-1:0]   iByte,
  input  logic                iByte_valid,
  input  logic                iByte_keep,
  input  logic                iByte_last,
  output logic                oByte_ready,
  output logic                oK_rst,
  output logic [WORD_W-1:0]   oK_data,
  output logic                oK_ready,
  output logic                oK_last,
  output logic [2:0]          oK_byte_num,
  input  logic                iK_buffer_full,
  input  logic [DIGEST_W-1:0] iK_data,
  input  logic                iK_ready,
  output logic [DIGEST_W-1:0] oDigest,
  output logic                oDigest_valid,
  input  logic                iDigest_ack
);

  state_e              state_q;
  logic [3:0]          krst_cnt_q;
  logic                last_pend_q;
  logic                k_last_q;
  logic [2:0]          byte_num_q;
  logic [DIGEST_W-1:0] digest_q;

  logic                beat;
  logic                consume;
  logic [CNT_W-1:0]    pk_cnt;
  logic [CNT_W-1:0]    cnt_new;
  logic [WORD_W-1:0]   pk_word;

  assign beat    = (state_q == ST_FILL) && iByte_valid;
  assign consume = ((state_q == ST_SEND) || (state_q == ST_SENDZ)) && !iK_buffer_full;
  assign cnt_new = pk_cnt + {{(CNT_W-1){1'b0}}, iByte_keep};

  sha3_byte_packer u_packer (
    .clk_i   (iClk),
    .rst_n_i (iRst_n),
    .wr_en_i (beat && iByte_keep),
    .byte_i  (iByte),
    .clr_i   (consume),
    .word_o  (pk_word),
    .cnt_o   (pk_cnt)
  );

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q     <= ST_KRST;
      krst_cnt_q  <= '0;
      last_pend_q <= 1'b0;
      k_last_q    <= 1'b0;
      byte_num_q  <= '0;
      digest_q    <= '0;
    end else begin
      case (state_q)
        ST_KRST: begin
          if (krst_cnt_q == 4'(KRST_CYCLES - 1)) begin
            krst_cnt_q <= '0;
            state_q    <= ST_FILL;
          end else begin
            krst_cnt_q <= krst_cnt_q + 4'd1;
          end
        end
        ST_FILL: begin
          if (beat) begin
            if (iByte_keep && (cnt_new == CNT_W'(LANES))) begin
              // A full final word still owes the core an empty terminating word.
              last_pend_q <= iByte_last;
              state_q     <= ST_SEND;
            end else if (iByte_last) begin
              k_last_q   <= 1'b1;
              byte_num_q <= cnt_new[2:0];
              state_q    <= ST_SEND;
            end
          end
        end
        ST_SEND: begin
          if (!iK_buffer_full) begin
            if (k_last_q) begin
              k_last_q   <= 1'b0;
              byte_num_q <= '0;
              state_q    <= ST_WAIT;
            end else if (last_pend_q) begin
              last_pend_q <= 1'b0;
              k_last_q    <= 1'b1;
              state_q     <= ST_SENDZ;
            end else begin
              state_q <= ST_FILL;
            end
          end
        end
        ST_SENDZ: begin
          if (!iK_buffer_full) begin
            k_last_q <= 1'b0;
            state_q  <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (iK_ready) begin
            digest_q <= iK_data;
            state_q  <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (iDigest_ack) state_q <= ST_KRST;
        end
        default: state_q <= ST_KRST;
      endcase
    end
  end

  // The packer word is already zero in SENDZ, so it drives oK_data directly.
  assign oByte_ready   = (state_q == ST_FILL);
  assign oK_rst        = (state_q == ST_KRST);
  assign oK_ready      = (state_q == ST_SEND) || (state_q == ST_SENDZ);
  assign oK_data       = pk_word;
  assign oK_last       = k_last_q;
  assign oK_byte_num   = byte_num_q;
  assign oDigest       = digest_q;
  assign oDigest_valid = (state_q == ST_DONE);

endmodule
